// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state type and Booth pair decode for the mul_div_unit engine.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // {q0, q-1}: 01 -> add multiplicand, 10 -> subtract, else shift only.
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        booth_op_e op;
        op = BOOTH_NOP;
        case (pair)
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/muldiv_iter_ctrl.sv
// Sequencer for mul_div_unit: IDLE/RUN/DONE state machine plus the per-bit iteration counter.
module muldiv_iter_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_start,
    input  logic i_skip,
    output logic o_accept,
    output logic o_run,
    output logic o_last,
    output logic o_done,
    output logic o_busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    muldiv_state_e r_state;
    muldiv_state_e w_state_next;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == RUN) begin
                r_cnt <= o_last ? '0 : r_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_accept     = 1'b0;
        o_run        = 1'b0;
        o_last       = 1'b0;
        o_done       = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    o_accept     = 1'b1;
                    w_state_next = i_skip ? DONE : RUN;
                end
            end
            RUN: begin
                o_run  = 1'b1;
                o_busy = 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    o_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                o_done       = 1'b1;
                o_busy       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) engine, one bit per clock.
// Define MULDIV_DIV_EN to build the divider; otherwise a DIV request completes at once with err set.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               op_div,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2*WIDTH-1:0] result
);

    logic w_accept;
    logic w_skip;
    logic w_run;
    logic w_last;
    logic w_done;
    logic w_busy;

    logic [2*WIDTH+1:0] r_mul_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]     w_booth_hi;
    logic [WIDTH:0]     w_booth_sum;
    logic [2*WIDTH+1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_final;

    logic [2*WIDTH-1:0] r_result;
    logic               r_err;

    muldiv_iter_ctrl #(
        .WIDTH(WIDTH)
    ) u_ctrl (
        .i_clk    (clk),
        .i_clr    (clr),
        .i_start  (start),
        .i_skip   (w_skip),
        .o_accept (w_accept),
        .o_run    (w_run),
        .o_last   (w_last),
        .o_done   (w_done),
        .o_busy   (w_busy)
    );

    assign busy   = w_busy;
    assign done   = w_done;
    assign err    = r_err;
    assign result = r_result;

    // Booth accumulator layout: {hi[WIDTH:0], multiplier[WIDTH-1:0], q-1}; the extra hi bit
    // keeps (-2^(W-1)) * (-2^(W-1)) from overflowing the partial sum.
    always_comb begin
        w_booth_hi  = r_mul_acc[2*WIDTH+1:WIDTH+1];
        w_booth_sum = w_booth_hi;
        case (booth_decode(r_mul_acc[1:0]))
            BOOTH_ADD: w_booth_sum = w_booth_hi + {r_mcand[WIDTH-1], r_mcand};
            BOOTH_SUB: w_booth_sum = w_booth_hi - {r_mcand[WIDTH-1], r_mcand};
            default:   w_booth_sum = w_booth_hi;
        endcase
        w_mul_next = {w_booth_sum[WIDTH], w_booth_sum, r_mul_acc[WIDTH:1]};
    end

`ifdef MULDIV_DIV_EN
    logic             r_op_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;

    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    assign w_skip = (op_div == OP_DIV) && (b_in == '0);

    // Remainder stays below the divisor, so the subtraction only needs WIDTH bits once
    // the full-width compare has decided the step succeeds.
    always_comb begin
        w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_dvsr});
        w_rem_diff = w_rem_sh[WIDTH-1:0] - r_dvsr;
        w_rem_next = w_ge ? w_rem_diff : w_rem_sh[WIDTH-1:0];
        w_quo_next = {r_quo[WIDTH-2:0], w_ge};
        w_quo_fix  = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
        w_rem_fix  = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
        w_final    = r_op_div ? {w_rem_fix, w_quo_fix} : w_mul_next[2*WIDTH:1];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_op_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
        end else if (w_accept) begin
            r_op_div <= (op_div == OP_DIV);
            r_neg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            r_neg_r  <= a_in[WIDTH-1];
            r_rem    <= '0;
            r_quo    <= f_mag(a_in);
            r_dvsr   <= f_mag(b_in);
        end else if (w_run) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
        end
    end
`else
    assign w_skip = (op_div == OP_DIV);

    always_comb begin
        w_final = w_mul_next[2*WIDTH:1];
    end
`endif

    // The last iteration's next-state value is written straight into result so it is
    // valid in the same cycle done rises.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_mul_acc <= '0;
            r_mcand   <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_mul_acc <= {{(WIDTH+1){1'b0}}, b_in, 1'b0};
            r_mcand   <= a_in;
            if (w_skip) begin
                r_err <= 1'b1;
`ifdef MULDIV_DIV_EN
                r_result <= {a_in, {WIDTH{1'b1}}};
`else
                r_result <= '0;
`endif
            end
        end else if (w_run) begin
            r_mul_acc <= w_mul_next;
            if (w_last) begin
                r_err    <= 1'b0;
                r_result <= w_final;
            end
        end
    end

endmodule
